// File: rtl/cache_bus_requester.sv
// Cache-side bus master: takes one line fill or write-back from the cache, bids for the
// memory bus, then issues an address beat followed by write beats or collected read beats.
module cache_bus_requester #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_req,
  input  logic                      miss_we,
  input  logic [ADDR_W-1:0]         miss_addr,
  input  logic [BEATS*DATA_W-1:0]   miss_wdata,
  output logic                      miss_ready,
  output logic                      fill_valid,
  output logic [BEATS*DATA_W-1:0]   fill_data,
  output logic                      wb_done,
  output logic                      bus_bid,
  input  logic                      bus_grant,
  output logic                      bus_reqcyc,
  output logic [DATA_W-1:0]         bus_req,
  output logic                      bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [DATA_W-1:0]         bus_resp,
  output logic                      bus_respack
);

  localparam int unsigned LINE_W = BEATS * DATA_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BID   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   fill_q, fill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      fill_q  <= fill_d;
    end
  end

  // Request beats only go out while the grant is actually held; a dropped grant freezes the beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    fill_d      = fill_q;
    miss_ready  = 1'b0;
    bus_bid     = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = 1'b0;
    bus_respack = 1'b0;
    fill_valid  = 1'b0;
    wb_done     = 1'b0;

    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) begin
          we_d    = miss_we;
          addr_d  = miss_addr;
          wline_d = miss_wdata;
          state_d = BID;
        end
      end
      BID: begin
        bus_bid = 1'b1;
        if (bus_grant) state_d = ADDR;
      end
      ADDR: begin
        bus_bid    = 1'b1;
        bus_reqcyc = bus_grant;
        bus_req    = DATA_W'(addr_q & ~ADDR_W'(6'h3f));
        bus_reqtag = we_q;
        if (bus_grant && bus_reqack) begin
          cnt_d   = '0;
          state_d = we_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        bus_bid    = 1'b1;
        bus_reqcyc = bus_grant;
        bus_req    = wline_q[int'(cnt_q)*DATA_W +: DATA_W];
        bus_reqtag = 1'b1;
        if (bus_grant && bus_reqack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      RDATA: begin
        bus_bid     = 1'b1;
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          fill_d[int'(cnt_q)*DATA_W +: DATA_W] = bus_resp;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        // Bid is low here so the arbiter always observes the release.
        fill_valid = ~we_q;
        wb_done    = we_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_data = fill_q;

endmodule

// File: tb/tb_cache_bus_requester.sv
// Randomized bench for cache_bus_requester: bench-driven arbiter/memory plus a transaction-level model.
module tb_cache_bus_requester;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = 8;
  localparam int unsigned LW = NB * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_req, miss_we, miss_ready;
  logic [AW-1:0] miss_addr;
  logic [LW-1:0] miss_wdata;
  logic          fill_valid, wb_done;
  logic [LW-1:0] fill_data;
  logic          bus_bid, bus_grant, bus_reqcyc, bus_reqtag, bus_reqack;
  logic [DW-1:0] bus_req, bus_resp;
  logic          bus_respcyc, bus_respack;

  cache_bus_requester #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_we(miss_we), .miss_addr(miss_addr), .miss_wdata(miss_wdata),
    .miss_ready(miss_ready), .fill_valid(fill_valid), .fill_data(fill_data), .wb_done(wb_done),
    .bus_bid(bus_bid), .bus_grant(bus_grant), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus configuration per transaction
  int            cfg_gdelay, cfg_ack_mode, cfg_ack_pct, cfg_resp_mode, cfg_stray_pct, cfg_drop_at;
  logic [DW-1:0] cfg_rline [NB];
  bit            drop_done;

  // Transaction-level model: what the bus must carry and when the cache sees completion
  typedef struct { logic [DW-1:0] d; logic t; } beat_t;
  beat_t         exp_req [$];
  logic [DW-1:0] log_req [$];
  bit            m_idle, m_bid, m_got_grant, m_done, m_we;
  int            m_hs, m_rd_cnt, m_bid_wait;
  logic [LW-1:0] m_acc, m_fill;

  task automatic model_finish();
    m_bid = 0; m_got_grant = 0; m_done = 1;
    if (!m_we) m_fill = m_acc;
    m_rd_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_idle = 1; m_bid = 0; m_got_grant = 0; m_done = 0; m_we = 0;
      m_hs = 0; m_rd_cnt = 0; m_fill = '0; m_acc = '0;
      exp_req.delete();
      chkw("reset_bus_req", LW'(bus_req), '0);
      chk1("reset_reqtag", bus_reqtag, 1'b0);
    end
    chk1("miss_ready", miss_ready, m_idle);
    chk1("bus_bid", bus_bid, m_bid);
    chk1("fill_valid", fill_valid, m_done && !m_we);
    chk1("wb_done", wb_done, m_done && m_we);
    chk1("bus_reqcyc", bus_reqcyc, m_got_grant && bus_grant && exp_req.size() > 0);
    if (m_got_grant && bus_grant && exp_req.size() > 0) begin
      chkw("bus_req", LW'(bus_req), LW'(exp_req[0].d));
      chk1("bus_reqtag", bus_reqtag, exp_req[0].t);
    end
    chk1("bus_respack", bus_respack,
         m_got_grant && exp_req.size() == 0 && !m_we && bus_respcyc);
    if (m_rd_cnt == 0) chkw("fill_data", fill_data, m_fill);

    if (!reset) begin
      if (m_done) begin
        m_done = 0; m_idle = 1;
      end else if (m_idle) begin
        if (miss_req) begin
          m_idle = 0; m_bid = 1; m_we = miss_we;
          m_hs = 0; m_rd_cnt = 0; m_bid_wait = 0;
          log_req.delete();
          exp_req.push_back('{d: miss_addr & ~64'h3f, t: miss_we});
          if (miss_we)
            for (int i = 0; i < NB; i++) exp_req.push_back('{d: miss_wdata[i*DW +: DW], t: 1'b1});
        end
      end else if (!m_got_grant) begin
        if (bus_grant) m_got_grant = 1;
        else m_bid_wait++;
      end else if (exp_req.size() > 0) begin
        if (bus_grant && bus_reqack) begin
          log_req.push_back(bus_req);
          void'(exp_req.pop_front());
          m_hs++;
          if (exp_req.size() == 0 && m_we) model_finish();
        end
      end else if (bus_respcyc) begin
        m_acc[m_rd_cnt*DW +: DW] = bus_resp;
        m_rd_cnt++;
        if (m_rd_cnt == NB) model_finish();
      end
    end
  end

  // Arbiter: grants after a configurable delay, optionally drops grant mid write for 2 cycles
  initial begin
    int gcnt, drop_left;
    gcnt = 0; drop_left = 0;
    bus_grant = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus_bid) begin
        gcnt = 0; drop_left = 0; bus_grant = 1'b0;
      end else begin
        gcnt++;
        if (drop_left > 0) begin
          bus_grant = 1'b0; drop_left--;
        end else if (cfg_drop_at >= 0 && !drop_done && m_got_grant && m_hs == cfg_drop_at + 1) begin
          bus_grant = 1'b0; drop_left = 1; drop_done = 1;
        end else begin
          bus_grant = (gcnt > cfg_gdelay);
        end
      end
    end
  end

  // Memory controller: request acks and response beats, with stray responses outside reads
  initial begin
    bit tog, alt, in_rd, send;
    tog = 1; alt = 1;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    forever begin
      @(posedge clk); #1;
      case (cfg_ack_mode)
        1:       bus_reqack = 1'b1;
        2:       begin bus_reqack = tog; tog = !tog; end
        default: bus_reqack = ($urandom_range(99) < cfg_ack_pct);
      endcase
      in_rd = m_got_grant && exp_req.size() == 0 && !m_we && !m_done && !reset;
      if (in_rd) begin
        case (cfg_resp_mode)
          0:       send = 1;
          1:       begin send = alt; alt = !alt; end
          default: send = $urandom_range(1);
        endcase
        bus_respcyc = send;
        bus_resp    = send ? cfg_rline[m_rd_cnt] : {$urandom, $urandom};
      end else begin
        alt = 1;
        bus_respcyc = ($urandom_range(99) < cfg_stray_pct);
        bus_resp    = {$urandom, $urandom};
      end
    end
  end

  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                        input bit early);
    bit got, ended;
    drop_done = 0;
    if (early) #2;
    else begin @(posedge clk); #1; end
    miss_req = 1'b1; miss_we = we; miss_addr = addr; miss_wdata = wd;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (miss_ready) got = 1;
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
    if (!got) begin
      chk1("accept_timeout", 1'b0, 1'b1);
      return;
    end
    ended = 0;
    for (int i = 0; i < 400 && !ended; i++) begin
      @(negedge clk);
      if (reset || fill_valid || wb_done) ended = 1;
    end
    if (!ended) chk1("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int gd, input int am, input int ap, input int rm, input int sp,
                         input int da);
    cfg_gdelay = gd; cfg_ack_mode = am; cfg_ack_pct = ap;
    cfg_resp_mode = rm; cfg_stray_pct = sp; cfg_drop_at = da;
  endtask

  initial begin
    logic [LW-1:0] wd;
    logic [DW-1:0] v;
    bit            reached;
    reset = 1'b1; miss_req = 1'b0; miss_we = 1'b0; miss_addr = '0; miss_wdata = '0;
    m_bid_wait = 0; drop_done = 0;
    set_cfg(2, 1, 100, 0, 0, -1);
    for (int i = 0; i < NB; i++) cfg_rline[i] = DW'(64'h10 + 64'(i));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Read fill at 0x1047, back-to-back response beats 0x10..0x17
    do_txn(1'b0, 64'h1047, '0, 0);
    chk1("rd_log_size", log_req.size() == 1, 1'b1);
    if (log_req.size() > 0) chkw("rd_addr_beat", LW'(log_req[0]), LW'(64'h1040));
    for (int i = 0; i < NB; i++) begin
      v = DW'(64'h10 + 64'(i));
      chkw("rd_fill_beat", LW'(fill_data[i*DW +: DW]), LW'(v));
    end

    // Write-back with toggling ack
    set_cfg(2, 2, 100, 0, 0, -1);
    for (int i = 0; i < NB; i++) wd[i*DW +: DW] = DW'(64'hA0 + 64'(i));
    do_txn(1'b1, 64'h2000, wd, 0);
    chk1("wb_log_size", log_req.size() == NB + 1, 1'b1);
    for (int i = 1; i < log_req.size(); i++) begin
      v = DW'(64'hA0 + 64'(i - 1));
      chkw("wb_beat", LW'(log_req[i]), LW'(v));
    end

    // Grant withheld for 10 cycles
    set_cfg(10, 1, 100, 0, 0, -1);
    for (int i = 0; i < NB; i++) cfg_rline[i] = {$urandom, $urandom};
    do_txn(1'b0, {$urandom, $urandom}, '0, 0);
    chkw("grant_wait_cycles", LW'(m_bid_wait), LW'(10));

    // Alternate-cycle responses, stray response beats everywhere else
    set_cfg(1, 1, 100, 1, 100, -1);
    for (int i = 0; i < NB; i++) cfg_rline[i] = {$urandom, $urandom};
    do_txn(1'b0, 64'h3fff, '0, 0);
    chkw("gapped_fill", fill_data,
         {cfg_rline[7], cfg_rline[6], cfg_rline[5], cfg_rline[4],
          cfg_rline[3], cfg_rline[2], cfg_rline[1], cfg_rline[0]});

    // Asynchronous reset after read beat 3
    set_cfg(1, 1, 100, 0, 0, -1);
    fork
      do_txn(1'b0, 64'h4040, '0, 0);
      begin
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
          @(negedge clk);
          if (m_rd_cnt == 4) reached = 1;
        end
        chk1("reach_beat3", reached, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk1("rst_miss_ready", miss_ready, 1'b1);
        chk1("rst_bid", bus_bid, 1'b0);
        chk1("rst_fill_valid", fill_valid, 1'b0);
        chkw("rst_fill_data", fill_data, '0);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    join
    for (int i = 0; i < NB; i++) cfg_rline[i] = {$urandom, $urandom};
    do_txn(1'b0, 64'h5000, '0, 0);
    chkw("post_rst_fill_b0", LW'(fill_data[DW-1:0]), LW'(cfg_rline[0]));

    // Grant drop for 2 cycles while write beat 4 is presented
    set_cfg(1, 1, 100, 0, 0, 4);
    for (int i = 0; i < NB; i++) wd[i*DW +: DW] = {$urandom, $urandom};
    do_txn(1'b1, 64'h6000, wd, 0);
    chk1("drop_happened", drop_done, 1'b1);
    chk1("drop_log_size", log_req.size() == NB + 1, 1'b1);
    for (int i = 1; i < log_req.size(); i++)
      chkw("drop_beat", LW'(log_req[i]), LW'(wd[(i-1)*DW +: DW]));

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      logic rw;
      rw = 1'($urandom_range(1));
      set_cfg($urandom_range(1, 4), 0, $urandom_range(30, 100), 2, 20,
              (rw && $urandom_range(1) == 1) ? $urandom_range(NB - 1) : -1);
      for (int i = 0; i < NB; i++) begin
        cfg_rline[i] = {$urandom, $urandom};
        wd[i*DW +: DW] = {$urandom, $urandom};
      end
      do_txn(rw, {$urandom, $urandom}, wd, $urandom_range(1) == 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_requester.md
Name: cache_bus_requester

Overview:
- Cache-side bus master interface, one instance each behind the instruction cache and the data cache.
- Accepts one line-fill (read) or line write-back request from its cache and raises a bid to the bus arbiter.
- Once granted, drives the memory-controller bus: an address beat, then write data beats or collected read response beats.
- Drops its bid when the transfer is complete, so the arbiter can return to idle.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, bus beat width
BEATS, 8, beats per cache line (line = BEATS*DATA_W = 512 bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
miss_req  in  1  cache request strobe, sampled only when miss_ready=1
miss_we  in  1  1=write-back, 0=line fill
miss_addr  in  ADDR_W  request address
miss_wdata  in  BEATS*DATA_W  write-back line; beat 0 = bits [DATA_W-1:0]
miss_ready  out  1  block idle, can accept a request
fill_valid  out  1  one-cycle pulse: fill_data holds a complete line
fill_data  out  BEATS*DATA_W  assembled read line; beat 0 = low bits
wb_done  out  1  one-cycle pulse: write-back complete
bus_bid  out  1  request to arbiter
bus_grant  in  1  grant from arbiter
bus_reqcyc  out  1  request beat valid
bus_req  out  DATA_W  address beat or write data beat
bus_reqtag  out  1  1=write, 0=read; valid with bus_reqcyc
bus_reqack  in  1  current request beat accepted
bus_respcyc  in  1  response beat valid
bus_resp  in  DATA_W  response data
bus_respack  out  1  response beat accepted

Behaviour:
- Single clock, clk.
- Asynchronous active-high reset: state=IDLE, beat counter=0.
- Reset values of outputs:
  - miss_ready=1; all other 1-bit outputs 0.
  - fill_data=0; bus_req=0; bus_reqtag=0.
- Reset mid-transfer aborts immediately with no completion pulse.
- State machine: IDLE, BID, ADDR, WDATA, RDATA, DONE.
- IDLE:
  - miss_ready=1.
  - When miss_req=1: latch miss_we, miss_addr and miss_wdata; go to BID.
  - miss_ready=0 in every other state.
- BID:
  - bus_bid=1.
  - Wait for bus_grant=1, which arrives at least 1 cycle after the bid rises; then go to ADDR.
  - bus_bid stays 1 in BID, ADDR, WDATA and RDATA.
- ADDR:
  - bus_reqcyc=1.
  - bus_req = latched address with bits [5:0] forced to 0 (line aligned).
  - bus_reqtag = latched we.
  - Held until bus_reqack=1; then go to WDATA if we=1, else RDATA; counter=0.
- WDATA:
  - bus_reqcyc=1, bus_req = line beat[counter].
  - Each cycle with bus_reqack=1, counter increments.
  - Ack on beat BEATS-1 -> DONE.
  - No response is expected for writes.
- RDATA:
  - bus_respack = bus_respcyc (combinational, same cycle).
  - Each cycle with bus_respcyc=1, bus_resp is written into line beat[counter] and counter increments.
  - Capture of beat BEATS-1 -> DONE.
- DONE:
  - bus_bid=0 for exactly 1 cycle, which guarantees the arbiter sees the bid drop.
  - fill_valid=1 for a read; wb_done=1 for a write.
  - Next state is IDLE.
  - fill_data holds the line from DONE until the next read's first captured beat.
- bus_grant falling while bus_bid=1 (protocol violation):
  - Drive bus_reqcyc=0 and freeze the counter.
  - Resume when the grant returns.
  - No beats are skipped or duplicated.
- bus_respcyc outside RDATA is ignored: bus_respack=0, no capture.
- bus_reqack outside ADDR/WDATA is ignored.
- miss_req while miss_ready=0 is ignored; the cache must hold it until miss_ready.
- Counter width is clog2(BEATS); the wrap at BEATS-1 coincides with the state exit.
- No back-to-back bid: minimum 1 bid-low cycle (DONE) plus IDLE before re-bidding, so at least 2 cycles.

Test Plan:
- Read fill:
  - Stimulus: miss_addr=0x1047, we=0; grant 2 cycles after bid; reqack on the first ADDR cycle; 8 resp beats 0x10..0x17 back-to-back.
  - Required: bus_req=0x1040, reqtag=0; fill_valid pulse 1 cycle after the last beat; fill_data beat i = 0x10+i; bid low in DONE.
- Write-back with backpressure:
  - Stimulus: we=1, wdata beats 0xA0..0xA7; reqack toggling 1,0,1,0.
  - Required: each beat is held until acked; exactly 8 data beats in order; wb_done pulse; no respack.
- Grant delay:
  - Stimulus: grant withheld 10 cycles.
  - Required: bid=1 and reqcyc=0 for all 10 cycles; ADDR begins the cycle after grant=1.
- Gapped response with stray beat:
  - Stimulus: respcyc pulses on alternate cycles; one stray respcyc in BID.
  - Required: stray beat not captured and respack=0; 8 beats assembled correctly.
- Reset mid-transfer:
  - Stimulus: async reset asserted after RDATA beat 3.
  - Required: immediately miss_ready=1, bid=0, fill_valid=0; a new request afterwards completes normally.
- Grant drop:
  - Stimulus: bus_grant falls for 2 cycles during WDATA beat 4.
  - Required: reqcyc=0 during the drop; resumes at beat 4; 8 total acked beats.
